// File: rtl/switch_press_decoder.sv
// Classifies debounced switch presses as SHORT, LONG or DOUBLE and emits one-cycle pulses.
// Optional auto-repeat while long-held is enabled by defining SWITCH_REPEAT_EN.
module switch_press_decoder #(
    parameter int unsigned c_LONG_LIMIT   = 12_500_000,
    parameter int unsigned c_DOUBLE_LIMIT = 6_250_000,
    parameter int unsigned c_REPEAT_LIMIT = 2_500_000,
    parameter int unsigned c_CNT_WIDTH    = 24
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Short,
    output logic o_Long,
    output logic o_Double,
    output logic o_Repeat,
    output logic o_Held
);

    localparam longint unsigned cnt_span = 64'd1 << c_CNT_WIDTH;

    // Every terminal count (limit-1) has to be representable in the shared counter.
    if (64'(c_LONG_LIMIT) > cnt_span || 64'(c_DOUBLE_LIMIT) > cnt_span ||
        64'(c_REPEAT_LIMIT) > cnt_span || c_LONG_LIMIT == 0 ||
        c_DOUBLE_LIMIT == 0 || c_REPEAT_LIMIT == 0) begin : g_bad_limits
        $error("switch_press_decoder: limits must be nonzero and fit in c_CNT_WIDTH bits");
    end

    localparam logic [c_CNT_WIDTH-1:0] long_last   = c_CNT_WIDTH'(c_LONG_LIMIT - 1);
    localparam logic [c_CNT_WIDTH-1:0] double_last = c_CNT_WIDTH'(c_DOUBLE_LIMIT - 1);
`ifdef SWITCH_REPEAT_EN
    localparam logic [c_CNT_WIDTH-1:0] repeat_last = c_CNT_WIDTH'(c_REPEAT_LIMIT - 1);
`endif

    // state     | meaning
    // IDLE      | waiting for a press
    // PRESSED   | first press held, timing toward LONG
    // WAIT_GAP  | released, timing the window for a second press
    // SECOND    | second press held until release
    // LONG_HELD | long press reported, waiting for release
    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        WAIT_GAP,
        SECOND,
        LONG_HELD
    } state_t;

    state_t                 state;
    logic [c_CNT_WIDTH-1:0] count;
    logic                   switch_last;
    logic                   rise;
    logic                   fall;

    assign rise = i_Switch & ~switch_last;
    assign fall = ~i_Switch & switch_last;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= IDLE;
            count       <= '0;
            switch_last <= i_Switch;
            o_Short     <= 1'b0;
            o_Long      <= 1'b0;
            o_Double    <= 1'b0;
            o_Held      <= 1'b0;
`ifdef SWITCH_REPEAT_EN
            o_Repeat    <= 1'b0;
`endif
        end else begin
            switch_last <= i_Switch;
            o_Held      <= i_Switch;
            o_Short     <= 1'b0;
            o_Long      <= 1'b0;
            o_Double    <= 1'b0;
`ifdef SWITCH_REPEAT_EN
            o_Repeat    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= PRESSED;
                        count <= '0;
                    end
                end
                PRESSED: begin
                    // A release on the terminal edge keeps the press short.
                    if (fall) begin
                        state <= WAIT_GAP;
                        count <= '0;
                    end else if (count == long_last) begin
                        state  <= LONG_HELD;
                        count  <= '0;
                        o_Long <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                WAIT_GAP: begin
                    if (rise) begin
                        state <= SECOND;
                        count <= '0;
                    end else if (count == double_last) begin
                        state   <= IDLE;
                        count   <= '0;
                        o_Short <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                SECOND: begin
                    if (fall) begin
                        state    <= IDLE;
                        count    <= '0;
                        o_Double <= 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        state <= IDLE;
                        count <= '0;
                    end
`ifdef SWITCH_REPEAT_EN
                    else if (count == repeat_last) begin
                        count    <= '0;
                        o_Repeat <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

`ifndef SWITCH_REPEAT_EN
    assign o_Repeat = 1'b0;
`endif

endmodule

// File: tb/tb_switch_press_decoder.sv
// Randomised and directed bench for switch_press_decoder, checked against a press/gap
// length model. A level sequence lvl[k] is the switch value sampled at edge k.
`timescale 1ns/1ps
module tb_switch_press_decoder;
    localparam int L    = 20;
    localparam int D    = 10;
    localparam int R    = 5;
    localparam int MAXN = 700;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sw  = 1'b0;
    logic o_short, o_long, o_double, o_repeat, o_held;

    int checks = 0;
    int errors = 0;

    bit       lvl [MAXN];
    int       n;
    logic [3:0] obs [MAXN];   // {repeat, double, long, short} seen after edge k
    logic       obs_held [MAXN];
    logic [3:0] expv [MAXN];

    always #5 clk = ~clk;

    switch_press_decoder #(
        .c_LONG_LIMIT  (L),
        .c_DOUBLE_LIMIT(D),
        .c_REPEAT_LIMIT(R),
        .c_CNT_WIDTH   (24)
    ) dut (
        .i_Clk   (clk),
        .i_Rst   (rst),
        .i_Switch(sw),
        .o_Short (o_short),
        .o_Long  (o_long),
        .o_Double(o_double),
        .o_Repeat(o_repeat),
        .o_Held  (o_held)
    );

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic clear_seq();
        n = 0;
    endtask

    task automatic add_seg(input bit v, input int len);
        for (int k = 0; k < len; k++) begin
            if (n < MAXN) begin
                lvl[n] = v;
                n++;
            end
        end
    endtask

    // Expected pulses in [s,e) starting fresh, with 'prev' the level sampled before s.
    // A press is a run of 1s of P samples starting at edge r and falling at r+P.
    // LONG at r+L if still high there; otherwise the gap opens at the fall f.
    // A new rise at f+G with G<=D makes a DOUBLE at that press's fall; else SHORT at f+D.
    task automatic model(input int s, input int e, input bit prev);
        int  i, j, f;
        bit  gap_open;
        f = 0;
        gap_open = 1'b0;
        i = s;
        while (i < e) begin
            j = i;
            while (j < e && lvl[j] == lvl[i]) j++;
            if (lvl[i] && !(i == s && prev)) begin
                if (gap_open && (i - f) <= D) begin
                    if (j < e) expv[j][2] = 1'b1;
                    gap_open = 1'b0;
                end else begin
                    if (gap_open) begin
                        expv[f + D][0] = 1'b1;
                        gap_open = 1'b0;
                    end
                    if (j - i >= L + 1) begin
                        expv[i + L][1] = 1'b1;
`ifdef SWITCH_REPEAT_EN
                        for (int t = i + L + R; t < j; t += R) expv[t][3] = 1'b1;
`endif
                    end else if (j < e) begin
                        f = j;
                        gap_open = 1'b1;
                    end
                end
            end
            i = j;
        end
        if (gap_open && f + D < e) expv[f + D][0] = 1'b1;
    endtask

    task automatic build_expected(input bit init, input int rst_at);
        for (int k = 0; k < MAXN; k++) expv[k] = 4'b0;
        if (rst_at < 0) begin
            model(0, n, init);
        end else begin
            model(0, rst_at, init);
            model(rst_at + 1, n, lvl[rst_at]);
        end
    endtask

    // Resets with the switch at 'init', then plays lvl[], pulsing reset at edge rst_at.
    task automatic play(input bit init, input int rst_at);
        @(negedge clk);
        sw  = init;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            rst = (k == rst_at);
            sw  = lvl[k];
            @(posedge clk);
            #1;
            obs[k]      = {o_repeat, o_double, o_long, o_short};
            obs_held[k] = o_held;
            @(negedge clk);
        end
        rst = 1'b0;
        sw  = 1'b0;
    endtask

    function automatic int n_pulses(input int b);
        int c = 0;
        for (int k = 0; k < n; k++) if (obs[k][b] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_pulse(input int b);
        for (int k = 0; k < n; k++) if (obs[k][b] === 1'b1) return k;
        return -1;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        sw  = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({o_short, o_long, o_double, o_repeat, o_held} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs_sw1: got %b required 00000",
                     {o_short, o_long, o_double, o_repeat, o_held});
        end
        @(negedge clk);
        sw = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({o_short, o_long, o_double, o_repeat, o_held} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs_sw0: got %b required 00000",
                     {o_short, o_long, o_double, o_repeat, o_held});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_short();
        clear_seq();
        add_seg(0, 3); add_seg(1, 6); add_seg(0, 31);
        play(1'b0, -1);
        build_expected(1'b0, -1);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs[k] !== expv[k] || obs_held[k] !== lvl[k]) begin
                errors++;
                $display("FAIL short_trace k=%0d: got pulses=%b held=%b required pulses=%b held=%b",
                         k, obs[k], obs_held[k], expv[k], lvl[k]);
            end
        end
        checks++;
        if (first_pulse(0) != 9 + D || n_pulses(0) != 1 || n_pulses(1) != 0 || n_pulses(2) != 0) begin
            errors++;
            $display("FAIL short_timing: got short@%0d x%0d long x%0d double x%0d required short@%0d x1, none else",
                     first_pulse(0), n_pulses(0), n_pulses(1), n_pulses(2), 9 + D);
        end
    endtask

    task automatic test_long();
        clear_seq();
        add_seg(0, 3); add_seg(1, 31); add_seg(0, 20);
        play(1'b0, -1);
        build_expected(1'b0, -1);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs[k] !== expv[k] || obs_held[k] !== lvl[k]) begin
                errors++;
                $display("FAIL long_trace k=%0d: got pulses=%b held=%b required pulses=%b held=%b",
                         k, obs[k], obs_held[k], expv[k], lvl[k]);
            end
        end
        checks++;
        if (first_pulse(1) != 3 + L || n_pulses(1) != 1 || n_pulses(0) != 0 || n_pulses(2) != 0) begin
            errors++;
            $display("FAIL long_timing: got long@%0d x%0d short x%0d double x%0d required long@%0d x1, none else",
                     first_pulse(1), n_pulses(1), n_pulses(0), n_pulses(2), 3 + L);
        end
    endtask

    task automatic test_double();
        clear_seq();
        add_seg(0, 3); add_seg(1, 5); add_seg(0, 7); add_seg(1, 41); add_seg(0, 15);
        play(1'b0, -1);
        build_expected(1'b0, -1);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs[k] !== expv[k] || obs_held[k] !== lvl[k]) begin
                errors++;
                $display("FAIL double_trace k=%0d: got pulses=%b held=%b required pulses=%b held=%b",
                         k, obs[k], obs_held[k], expv[k], lvl[k]);
            end
        end
        checks++;
        if (first_pulse(2) != 56 || n_pulses(2) != 1 || n_pulses(0) != 0 || n_pulses(1) != 0) begin
            errors++;
            $display("FAIL double_timing: got double@%0d x%0d short x%0d long x%0d required double@56 x1, none else",
                     first_pulse(2), n_pulses(2), n_pulses(0), n_pulses(1));
        end
    endtask

    // Case 0: held 20 cycles past the rise; 1: held 19 (release on the LONG terminal edge);
    // 2: gap of 10 after release then a press; 3: gap of 9 (rise on the window terminal edge).
    task automatic test_boundaries();
        int want_s, want_l, want_d;
        for (int c = 0; c < 4; c++) begin
            clear_seq();
            add_seg(0, 3);
            case (c)
                0: begin add_seg(1, 21); add_seg(0, 15); want_s = 0; want_l = 1; want_d = 0; end
                1: begin add_seg(1, 20); add_seg(0, 15); want_s = 1; want_l = 0; want_d = 0; end
                2: begin add_seg(1, 4); add_seg(0, 11); add_seg(1, 4); add_seg(0, 15);
                         want_s = 2; want_l = 0; want_d = 0; end
                default: begin add_seg(1, 4); add_seg(0, 10); add_seg(1, 4); add_seg(0, 15);
                               want_s = 0; want_l = 0; want_d = 1; end
            endcase
            play(1'b0, -1);
            build_expected(1'b0, -1);
            for (int k = 0; k < n; k++) begin
                checks++;
                if (obs[k] !== expv[k] || obs_held[k] !== lvl[k]) begin
                    errors++;
                    $display("FAIL boundary%0d_trace k=%0d: got pulses=%b held=%b required pulses=%b held=%b",
                             c, k, obs[k], obs_held[k], expv[k], lvl[k]);
                end
            end
            checks++;
            if (n_pulses(0) != want_s || n_pulses(1) != want_l || n_pulses(2) != want_d) begin
                errors++;
                $display("FAIL boundary%0d_counts: got s/l/d=%0d/%0d/%0d required %0d/%0d/%0d",
                         c, n_pulses(0), n_pulses(1), n_pulses(2), want_s, want_l, want_d);
            end
        end
    endtask

    task automatic test_reset_held();
        clear_seq();
        add_seg(1, 10); add_seg(0, 3); add_seg(1, 4); add_seg(0, 20);
        play(1'b1, -1);
        build_expected(1'b1, -1);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs[k] !== expv[k] || obs_held[k] !== lvl[k]) begin
                errors++;
                $display("FAIL reset_held_trace k=%0d: got pulses=%b held=%b required pulses=%b held=%b",
                         k, obs[k], obs_held[k], expv[k], lvl[k]);
            end
        end
        checks++;
        if (first_pulse(0) != 17 + D || n_pulses(0) != 1 || n_pulses(1) != 0 || n_pulses(2) != 0) begin
            errors++;
            $display("FAIL reset_held_short: got short@%0d x%0d long x%0d double x%0d required short@%0d x1",
                     first_pulse(0), n_pulses(0), n_pulses(1), n_pulses(2), 17 + D);
        end
    endtask

    // Reset pulsed while in PRESSED, WAIT_GAP and SECOND; the common tail yields one SHORT.
    task automatic test_reset_mid();
        int rst_at;
        for (int c = 0; c < 3; c++) begin
            clear_seq();
            add_seg(0, 2);
            case (c)
                0: begin add_seg(1, 8); rst_at = 5; end
                1: begin add_seg(1, 4); add_seg(0, 6); rst_at = 9; end
                default: begin add_seg(1, 4); add_seg(0, 3); add_seg(1, 5); rst_at = 11; end
            endcase
            add_seg(0, 5); add_seg(1, 4); add_seg(0, 20);
            play(1'b0, rst_at);
            build_expected(1'b0, rst_at);
            for (int k = 0; k < n; k++) begin
                checks++;
                if (obs[k] !== expv[k] || obs_held[k] !== ((k == rst_at) ? 1'b0 : lvl[k])) begin
                    errors++;
                    $display("FAIL reset_mid%0d_trace k=%0d: got pulses=%b held=%b required pulses=%b",
                             c, k, obs[k], obs_held[k], expv[k]);
                end
            end
            checks++;
            if (n_pulses(0) != 1 || n_pulses(1) != 0 || n_pulses(2) != 0 || n_pulses(3) != 0) begin
                errors++;
                $display("FAIL reset_mid%0d_counts: got s/l/d/r=%0d/%0d/%0d/%0d required 1/0/0/0",
                         c, n_pulses(0), n_pulses(1), n_pulses(2), n_pulses(3));
            end
        end
    endtask

    task automatic test_random();
        int rst_at;
        for (int it = 0; it < 8; it++) begin
            clear_seq();
            add_seg(0, int'($urandom_range(1, 5)));
            while (n < 450) begin
                add_seg(1, int'($urandom_range(1, 30)));
                if ($urandom_range(0, 4) == 0) add_seg(0, int'($urandom_range(8, 14)));
                else add_seg(0, int'($urandom_range(1, 14)));
            end
            rst_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(10, 400)) : -1;
            play(1'b0, rst_at);
            build_expected(1'b0, rst_at);
            for (int k = 0; k < n; k++) begin
                checks++;
                if (obs[k] !== expv[k] || obs_held[k] !== ((k == rst_at) ? 1'b0 : lvl[k])) begin
                    errors++;
                    $display("FAIL random%0d_trace k=%0d: got pulses=%b held=%b required pulses=%b",
                             it, k, obs[k], obs_held[k], expv[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_double();
        test_boundaries();
        test_reset_held();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
